// File: rtl/irq_controller_if.sv
//------------------------------------------------------------------------------
// Module   : irq_controller_if
// Brief    : picorv32 native memory bus bundle for the interrupt controller.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface irq_controller_if;
  logic        mem_valid;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  modport master (
    output mem_valid, mem_addr, mem_wstrb, mem_wdata,
    input  mem_rdata, mem_ready
  );

  modport slave (
    input  mem_valid, mem_addr, mem_wstrb, mem_wdata,
    output mem_rdata, mem_ready
  );
endinterface

`default_nettype wire

// File: rtl/irq_controller.sv
//------------------------------------------------------------------------------
// Module   : irq_controller
// Brief    : Memory-mapped interrupt controller for the picorv32 irq/eoi port.
//            Optional macro IRQC_EOI_CLEAR_EN: falling eoi_in clears edge lines.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module irq_controller #(
  parameter int          NUM_IRQ     = 16,
  parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
  parameter int          SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rstn,
  irq_controller_if.slave    bus,
  input  logic [NUM_IRQ-1:0] irq_in,
  output logic [31:0]        irq_out,
  input  logic [31:0]        eoi_in
);

  localparam logic [5:0] C_OFF_PENDING = 6'h00;
  localparam logic [5:0] C_OFF_ENABLE  = 6'h01;
  localparam logic [5:0] C_OFF_MODE    = 6'h02;
  localparam logic [5:0] C_OFF_STATUS  = 6'h03;
  localparam logic [5:0] C_OFF_SWSET   = 6'h04;

  logic [NUM_IRQ-1:0] r_sync [SYNC_STAGES];
  logic [NUM_IRQ-1:0] r_s_d;
  logic [NUM_IRQ-1:0] r_pending;
  logic [NUM_IRQ-1:0] r_enable;
  logic [NUM_IRQ-1:0] r_mode;
  logic               r_ready;
  logic [31:0]        r_rdata;
  logic [31:0]        r_irq_out;

  logic               w_sel;
  logic               w_wr;
  logic [5:0]         w_off;
  logic [31:0]        w_bmask32;
  logic [NUM_IRQ-1:0] w_bmask;
  logic [NUM_IRQ-1:0] w_wdata;
  logic [NUM_IRQ-1:0] w_s;
  logic [NUM_IRQ-1:0] w_edge;
  logic [NUM_IRQ-1:0] w_clr;
  logic [NUM_IRQ-1:0] w_swset;
  logic [NUM_IRQ-1:0] w_set;
  logic [NUM_IRQ-1:0] w_eoi_clr;
  logic [NUM_IRQ-1:0] w_enable_n;
  logic [NUM_IRQ-1:0] w_mode_n;
  logic [NUM_IRQ-1:0] w_pending_n;
  logic [31:0]        w_rdata;
  logic               w_unused_bits;

  // !r_ready forces an idle cycle so one request is never answered twice.
  assign w_sel     = bus.mem_valid && (bus.mem_addr[31:8] == BASE_ADDR[31:8]) && !r_ready;
  assign w_wr      = w_sel && (bus.mem_wstrb != 4'b0000);
  assign w_off     = bus.mem_addr[7:2];
  assign w_bmask32 = {{8{bus.mem_wstrb[3]}}, {8{bus.mem_wstrb[2]}},
                      {8{bus.mem_wstrb[1]}}, {8{bus.mem_wstrb[0]}}};
  assign w_bmask   = w_bmask32[NUM_IRQ-1:0];
  assign w_wdata   = bus.mem_wdata[NUM_IRQ-1:0];

  assign w_s    = r_sync[SYNC_STAGES-1];
  assign w_edge = w_s & ~r_s_d;

`ifdef IRQC_EOI_CLEAR_EN
  logic [31:0] r_eoi_d;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_eoi_d <= '0;
    end else begin
      r_eoi_d <= eoi_in;
    end
  end

  assign w_eoi_clr     = r_eoi_d[NUM_IRQ-1:0] & ~eoi_in[NUM_IRQ-1:0];
  assign w_unused_bits = ^{bus.mem_addr[1:0], bus.mem_wdata, w_bmask32, eoi_in, r_eoi_d};
`else
  assign w_eoi_clr     = '0;
  assign w_unused_bits = ^{bus.mem_addr[1:0], bus.mem_wdata, w_bmask32, eoi_in};
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        r_sync[k] <= '0;
      end
      r_s_d <= '0;
    end else begin
      r_sync[0] <= irq_in;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        r_sync[k] <= r_sync[k-1];
      end
      r_s_d <= w_s;
    end
  end

  always_comb begin
    w_enable_n = r_enable;
    w_mode_n   = r_mode;
    w_clr      = '0;
    w_swset    = '0;
    if (w_wr) begin
      case (w_off)
        C_OFF_PENDING: w_clr      = w_wdata & w_bmask;
        C_OFF_ENABLE:  w_enable_n = (r_enable & ~w_bmask) | (w_wdata & w_bmask);
        C_OFF_MODE:    w_mode_n   = (r_mode & ~w_bmask) | (w_wdata & w_bmask);
        C_OFF_SWSET:   w_swset    = w_wdata & w_bmask;
        default:       ;
      endcase
    end
    // Sets are ORed in after clears so a same-cycle set always wins.
    w_set       = w_edge | w_swset;
    w_pending_n = (r_mode & ((r_pending & ~(w_clr | w_eoi_clr)) | w_set))
                | (~r_mode & w_s);
  end

  always_comb begin
    w_rdata = '0;
    case (w_off)
      C_OFF_PENDING: w_rdata = 32'(r_pending);
      C_OFF_ENABLE:  w_rdata = 32'(r_enable);
      C_OFF_MODE:    w_rdata = 32'(r_mode);
      C_OFF_STATUS:  w_rdata = 32'(r_pending & r_enable);
      default:       w_rdata = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_pending <= '0;
      r_enable  <= '0;
      r_mode    <= '0;
      r_irq_out <= '0;
    end else begin
      r_pending <= w_pending_n;
      r_enable  <= w_enable_n;
      r_mode    <= w_mode_n;
      r_irq_out <= 32'(r_pending & r_enable);
    end
  end

  // Outputs idle at zero so several slaves can be ORed onto the core bus.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_ready <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_ready <= w_sel;
      r_rdata <= w_sel ? w_rdata : 32'h0;
    end
  end

  assign bus.mem_ready = r_ready;
  assign bus.mem_rdata = r_rdata;
  assign irq_out       = r_irq_out;

endmodule

`default_nettype wire

// File: tb/tb_irq_controller.sv
//------------------------------------------------------------------------------
// Module   : tb_irq_controller
// Brief    : Directed bench for irq_controller (16-line and 8-line instances).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_irq_controller;

  localparam logic [31:0] C_BASE   = 32'h1000_0000;
  localparam logic [31:0] C_BASE8  = 32'h1000_0100;
  localparam logic [31:0] C_PEND   = C_BASE + 32'h00;
  localparam logic [31:0] C_EN     = C_BASE + 32'h04;
  localparam logic [31:0] C_MODE   = C_BASE + 32'h08;
  localparam logic [31:0] C_STAT   = C_BASE + 32'h0C;
  localparam logic [31:0] C_SWSET  = C_BASE + 32'h10;

  logic        clk;
  logic        rstn;
  logic        tb_valid;
  logic [31:0] tb_addr;
  logic [3:0]  tb_wstrb;
  logic [31:0] tb_wdata;
  logic [15:0] irq_in;
  logic [7:0]  irq_in8;
  logic [31:0] irq_out;
  logic [31:0] irq_out8;
  logic [31:0] eoi_in;
  logic [31:0] eoi_in8;
  logic        w_ready;
  logic [31:0] w_rdata;

  int n_checks = 0;
  int n_errors = 0;

  irq_controller_if u_bus ();
  irq_controller_if u_bus8 ();

  assign u_bus.mem_valid  = tb_valid;
  assign u_bus.mem_addr   = tb_addr;
  assign u_bus.mem_wstrb  = tb_wstrb;
  assign u_bus.mem_wdata  = tb_wdata;
  assign u_bus8.mem_valid = tb_valid;
  assign u_bus8.mem_addr  = tb_addr;
  assign u_bus8.mem_wstrb = tb_wstrb;
  assign u_bus8.mem_wdata = tb_wdata;
  assign w_ready = u_bus.mem_ready | u_bus8.mem_ready;
  assign w_rdata = u_bus.mem_rdata | u_bus8.mem_rdata;

  irq_controller #(.NUM_IRQ(16), .BASE_ADDR(C_BASE), .SYNC_STAGES(2)) u_dut (
    .clk     (clk),
    .rstn    (rstn),
    .bus     (u_bus),
    .irq_in  (irq_in),
    .irq_out (irq_out),
    .eoi_in  (eoi_in)
  );

  irq_controller #(.NUM_IRQ(8), .BASE_ADDR(C_BASE8), .SYNC_STAGES(2)) u_dut8 (
    .clk     (clk),
    .rstn    (rstn),
    .bus     (u_bus8),
    .irq_in  (irq_in8),
    .irq_out (irq_out8),
    .eoi_in  (eoi_in8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Every access also checks that mem_ready arrives exactly one cycle later.
  task automatic xfer(input string tag, input logic [31:0] addr, input logic [3:0] strb,
                      input logic [31:0] data, output logic [31:0] rdata);
    int lat;
    @(posedge clk);
    #1;
    tb_valid = 1'b1;
    tb_addr  = addr;
    tb_wstrb = strb;
    tb_wdata = data;
    lat      = 0;
    rdata    = '0;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk);
      #1;
      if (w_ready) begin
        lat   = k;
        rdata = w_rdata;
        break;
      end
    end
    tb_valid = 1'b0;
    tb_wstrb = 4'b0000;
    check({tag, "_latency"}, 32'(lat), 32'd1);
  endtask

  task automatic wr(input string tag, input logic [31:0] addr, input logic [3:0] strb,
                    input logic [31:0] data);
    logic [31:0] dummy;
    xfer(tag, addr, strb, data, dummy);
  endtask

  task automatic rd_check(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    logic [31:0] v;
    xfer(tag, addr, 4'b0000, 32'h0, v);
    check(tag, v, exp);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rstn     = 1'b0;
    tb_valid = 1'b0;
    tb_addr  = '0;
    tb_wstrb = '0;
    tb_wdata = '0;
    irq_in   = '0;
    irq_in8  = '0;
    eoi_in   = '0;
    eoi_in8  = '0;
    tick(3);
    check("rst_ready", 32'(w_ready), 32'd0);
    check("rst_rdata", w_rdata, 32'h0);
    check("rst_irq_out", irq_out, 32'h0);
    rstn = 1'b1;
    tick(1);

    for (int i = 0; i < 5; i++) begin
      rd_check($sformatf("rst_rd_%0d", i), C_BASE + 32'(4 * i), 32'h0);
    end
    check("rst_irq_out_after", irq_out, 32'h0);

    // Access outside both windows must leave the bus silent.
    tb_valid = 1'b1;
    tb_addr  = 32'h2000_0000;
    tick(2);
    check("unsel_ready", 32'(w_ready), 32'd0);
    check("unsel_rdata", w_rdata, 32'h0);
    tb_valid = 1'b0;

    // Edge line 0: four-cycle latency, sticky, W1C
    wr("mode0", C_MODE, 4'hF, 32'h1);
    wr("en0", C_EN, 4'hF, 32'h1);
    irq_in[0] = 1'b1;
    tick(1);
    irq_in[0] = 1'b0;
    tick(2);
    check("edge0_cyc3", irq_out, 32'h0);
    tick(1);
    check("edge0_cyc4", irq_out, 32'h1);
    tick(3);
    check("edge0_sticky", irq_out, 32'h1);
    rd_check("edge0_pend", C_PEND, 32'h1);
    wr("edge0_w1c", C_PEND, 4'hF, 32'h1);
    check("edge0_w1c_same", irq_out, 32'h1);
    tick(1);
    check("edge0_w1c_next", irq_out, 32'h0);

    // Level line 3
    wr("en3", C_EN, 4'hF, 32'h9);
    irq_in[3] = 1'b1;
    tick(5);
    check("lvl3_on", irq_out, 32'h8);
    wr("lvl3_w1c", C_PEND, 4'hF, 32'h8);
    tick(2);
    check("lvl3_w1c_noeff", irq_out, 32'h8);
    rd_check("lvl3_pend", C_PEND, 32'h8);
    irq_in[3] = 1'b0;
    tick(3);
    check("lvl3_drop_cyc3", irq_out, 32'h8);
    tick(1);
    check("lvl3_drop_cyc4", irq_out, 32'h0);

    // Disabled edge line 5, then enable
    wr("en_off", C_EN, 4'hF, 32'h0);
    wr("mode5", C_MODE, 4'hF, 32'h21);
    irq_in[5] = 1'b1;
    tick(1);
    irq_in[5] = 1'b0;
    tick(5);
    rd_check("dis5_pend", C_PEND, 32'h20);
    rd_check("dis5_stat", C_STAT, 32'h0);
    check("dis5_irq", irq_out, 32'h0);
    wr("en5", C_EN, 4'hF, 32'h20);
    check("en5_same", irq_out, 32'h0);
    tick(1);
    check("en5_next", irq_out, 32'h20);
    rd_check("en5_stat", C_STAT, 32'h20);
    wr("clr5", C_PEND, 4'hF, 32'h20);

    // Edge on line 2 lands on the same edge as its W1C
    wr("mode2", C_MODE, 4'hF, 32'h25);
    irq_in[2] = 1'b1;
    tick(1);
    wr("race2_w1c", C_PEND, 4'hF, 32'h4);
    irq_in[2] = 1'b0;
    rd_check("race2_pend", C_PEND, 32'h4);
    wr("clr2", C_PEND, 4'hF, 32'h4);
    rd_check("clr2_pend", C_PEND, 32'h0);

    // SWSET only affects edge lines; reads back 0
    wr("swset", C_SWSET, 4'hF, 32'h0000_FFFF);
    rd_check("swset_pend", C_PEND, 32'h25);
    rd_check("swset_rd", C_SWSET, 32'h0);

    // Edge->level reloads from input; level->edge keeps value
    irq_in[4] = 1'b1;
    wr("to_level", C_MODE, 4'hF, 32'h0);
    tick(3);
    rd_check("to_level_pend", C_PEND, 32'h10);
    wr("to_edge", C_MODE, 4'hF, 32'h10);
    tick(2);
    rd_check("to_edge_pend", C_PEND, 32'h10);
    irq_in[4] = 1'b0;
    tick(4);
    rd_check("to_edge_hold", C_PEND, 32'h10);
    wr("clr4", C_PEND, 4'hF, 32'h10);

    // Byte strobes and NUM_IRQ=8 masking
    wr("en_zero", C_EN, 4'hF, 32'h0);
    wr("en_byte1", C_EN, 4'b0010, 32'hFFFF_FFFF);
    rd_check("en_byte1_rd", C_EN, 32'h0000_FF00);
    wr("en8_byte1", C_BASE8 + 32'h4, 4'b0010, 32'hFFFF_FFFF);
    rd_check("en8_byte1_rd", C_BASE8 + 32'h4, 32'h0);
    wr("en8_full", C_BASE8 + 32'h4, 4'hF, 32'hFFFF_FFFF);
    rd_check("en8_full_rd", C_BASE8 + 32'h4, 32'h0000_00FF);

    // EOI handling on edge line 1
    wr("mode1", C_MODE, 4'hF, 32'h2);
    wr("en1", C_EN, 4'hF, 32'h2);
    irq_in[1] = 1'b1;
    tick(1);
    irq_in[1] = 1'b0;
    tick(5);
    rd_check("eoi1_pend", C_PEND, 32'h2);
    eoi_in[1] = 1'b1;
    tick(2);
    rd_check("eoi1_rise", C_PEND, 32'h2);
    eoi_in[1] = 1'b0;
    tick(2);
`ifdef IRQC_EOI_CLEAR_EN
    rd_check("eoi1_fall", C_PEND, 32'h0);
`else
    rd_check("eoi1_fall", C_PEND, 32'h2);
`endif

    // Asynchronous reset clears irq_out without a clock edge
    wr("pre_rst_swset", C_SWSET, 4'hF, 32'h2);
    tick(2);
    check("pre_rst_irq", irq_out, 32'h2);
    #2;
    rstn = 1'b0;
    #1;
    check("async_rst_irq", irq_out, 32'h0);
    tick(2);
    rstn = 1'b1;
    tick(1);
    rd_check("post_rst_en", C_EN, 32'h0);
    rd_check("post_rst_mode", C_MODE, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/irq_controller.md
Name: irq_controller

Overview:
- Parametrised interrupt controller between external interrupt sources and the picorv32 core's `irq`/`eoi` interface.
- Replaces the hard-wired 16-line direct connection.
- Adds per-line input synchronisation, edge/level mode, enable masking, sticky pending state and software trigger.
- All state is memory-mapped as a slave on the picorv32 native memory bus, alongside the SRAM.

Parameters:
- NUM_IRQ, 16, number of interrupt lines (1..32); register bits at or above NUM_IRQ read 0 and ignore writes.
- BASE_ADDR, 32'h1000_0000, 256-byte-aligned base of the register window.
- SYNC_STAGES, 2, flop stages on each irq_in line (minimum 2).

Ports:
- clk  in  1  system clock.
- rstn  in  1  asynchronous active-low reset.
- mem_valid  in  1  core bus request valid.
- mem_addr  in  32  byte address.
- mem_wstrb  in  4  byte write strobes; 0 = read.
- mem_wdata  in  32  write data.
- mem_rdata  out  32  read data, valid while mem_ready=1, else 0.
- mem_ready  out  1  one-cycle response strobe for accesses hitting this window.
- irq_in  in  NUM_IRQ  asynchronous external interrupt sources.
- irq_out  out  32  to core irq; bits [NUM_IRQ-1:0] = STATUS, upper bits 0.
- eoi_in  in  32  from core eoi.

Behaviour:
- Reset (async, rstn=0): PENDING, ENABLE, MODE, sync chains and response state cleared; mem_ready=0, mem_rdata=0, irq_out=0 immediately.
- Window select: sel = mem_valid && mem_addr[31:8]==BASE_ADDR[31:8] && !mem_ready.
- Response timing: mem_ready=1 exactly one cycle after sel, for one cycle, then 0 for at least one cycle. Back-to-back accesses therefore take 2 cycles each. Register writes take effect on the mem_ready edge.
- Register map (offset mem_addr[7:2]):
  - 0x00 PENDING: R; write-1-to-clear.
  - 0x04 ENABLE: RW.
  - 0x08 MODE: RW; 1 = edge, 0 = level.
  - 0x0C STATUS: R; PENDING & ENABLE.
  - 0x10 SWSET: W; write-1-sets PENDING for edge-mode lines; reads 0.
  - All other offsets read 0; writes ignored.
- Byte strobes: RW/W1C/W1S apply only to bytes with mem_wstrb set.
- Synchronisation: irq_in[i] passes SYNC_STAGES flops giving s[i]; an extra flop gives s_d[i].
- Edge mode: s[i] & ~s_d[i] sets PENDING[i].
- Level mode: PENDING[i] follows s[i] each cycle; W1C and SWSET have no lasting effect.
- Simultaneous set and clear in one cycle: set wins (hardware edge, SWSET or EOI-clear vs. set, all cases).
- MODE change edge→level: PENDING reloads from s[i] the next cycle. Level→edge: PENDING keeps its current value.
- irq_out: registered, = PENDING & ENABLE, one cycle after the state update.
- Latency: irq_in rising edge to irq_out=1 is SYNC_STAGES+2 cycles (4 at default), with ENABLE set.
- Unselected bus cycles: outputs stay 0 so the SoC can OR mem_ready/mem_rdata across slaves.
- Reset asserted mid-access: the access is dropped; the core re-issues after reset.

Optional Feature:
- Macro: IRQC_EOI_CLEAR_EN.
- Defined: a falling edge of eoi_in[i] (core handler return) clears PENDING[i] for edge-mode lines. Level-mode lines are unaffected. A same-cycle new edge still sets PENDING. Requires one extra 32-bit eoi_in delay register.
- Undefined: eoi_in is ignored; edge-mode pending bits clear only via W1C.

Test Plan:
- Reset, then read offsets 0x00..0x10 -> all 0; mem_ready high exactly 1 cycle after mem_valid; irq_out=0.
- MODE=0x1, ENABLE=0x1, pulse irq_in[0] high for 1 cycle -> irq_out[0]=1 exactly 4 cycles later and stays 1; PENDING read=0x1; write 0x1 to 0x00 -> irq_out[0]=0 the cycle after.
- Level line 3 (MODE[3]=0, ENABLE[3]=1): irq_in[3] held high -> irq_out[3]=1; W1C 0x8 -> still 1; drop irq_in[3] -> irq_out[3]=0 after 4 cycles.
- ENABLE=0, edge on line 5 -> PENDING=0x20, STATUS=0, irq_out=0; then ENABLE=0x20 -> irq_out[5]=1 next cycle.
- Edge on line 2 arriving in the same cycle as W1C of bit 2 -> PENDING[2] remains 1. Byte write with wstrb=4'b0010 of 0xFFFF_FFFF to ENABLE -> ENABLE=0x0000_FF00. NUM_IRQ=8 build -> ENABLE=0x0000_0000.
- With IRQC_EOI_CLEAR_EN: edge line 1 pending, eoi_in[1] 0→1→0 -> PENDING[1] cleared on the fall. Without the macro -> PENDING[1] stays 1.
